// File: rtl/pipe_fetch_queue_pkg.sv
// Shared CPU constants for the fetch/decode pipeline: NOP encoding, default
// fetch-queue depth and the {pc4, ins} entry layout.
package pipe_fetch_queue_pkg;

    localparam int          FQ_DEPTH_DEFAULT = 4;
    localparam logic [31:0] NOP_INS_DEFAULT  = 32'h00000000;  // sll $0,$0,0
    localparam int          FQ_ENTRY_W       = 64;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } fq_entry_t;

    function automatic fq_entry_t fq_pack(input logic [31:0] pc4, input logic [31:0] ins);
        fq_entry_t e;
        e.pc4 = pc4;
        e.ins = ins;
        return e;
    endfunction

endpackage

// File: rtl/pipe_fetch_queue_fq_ptr_ctrl.sv
// Read/write pointer and occupancy control for the fetch queue; handshake
// qualification lives here so the storage array only sees a write strobe.
module fq_ptr_ctrl
    import pipe_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       push,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       in_ready,
    output logic                       out_valid
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic pop;

    // Ready/valid come from registered occupancy only, so a pop cannot make
    // room for a push in the same cycle.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction fetch queue decoupling IF from ID: DEPTH-entry FIFO of
// {pc4, ins} pairs with one-cycle latency and flush for redirects.
module pipe_fetch_queue
    import pipe_fetch_queue_pkg::*;
#(
    parameter int          DEPTH   = FQ_DEPTH_DEFAULT,
    parameter logic [31:0] NOP_INS = NOP_INS_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [31:0]             in_pc4,
    input  logic [31:0]             in_ins,
    output logic                    in_ready,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [31:0]             out_pc4,
    output logic [31:0]             out_ins,
    output logic [$clog2(DEPTH):0]  count
);

    logic                     push;
    logic [$clog2(DEPTH)-1:0] wr_ptr;
    logic [$clog2(DEPTH)-1:0] rd_ptr;
    fq_entry_t                mem [DEPTH];
    fq_entry_t                head;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );

    // Storage is left unreset; stale entries are masked by out_valid below.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= fq_pack(in_pc4, in_ins);
    end

    assign head    = mem[rd_ptr];
    assign out_ins = out_valid ? head.ins : NOP_INS;
    assign out_pc4 = out_valid ? head.pc4 : 32'h0;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Scoreboard-based bench for pipe_fetch_queue: expected entries are queued
// when a push is driven and compared against out_* as they are consumed.
module tb_pipe_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc4;
    logic [31:0] in_ins;
    logic        in_ready;
    logic        out_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc4;
    logic [31:0] out_ins;
    logic [2:0]  count;

    logic [63:0] sb [$];
    int checks = 0;
    int errors = 0;

    pipe_fetch_queue #(.DEPTH(DEPTH), .NOP_INS(NOP)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc4    (in_pc4),
        .in_ins    (in_ins),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc4   (out_pc4),
        .out_ins   (out_ins),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_pc4    = 32'h0;
        in_ins    = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc4   = 32'h44;
        in_ins   = 32'hDEAD0000;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ins !== NOP) begin errors++; $display("FAIL reset_out_ins: got %h want %h", out_ins, NOP); end
        checks++; if (out_pc4 !== 32'h0) begin errors++; $display("FAIL reset_out_pc4: got %h want 0", out_pc4); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_stays_empty: count=%0d out_valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_fill_full();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_pc4   = 32'(4 * (i + 1));
            in_ins   = 32'h1000 + 32'(i);
            sb.push_back({in_pc4, in_ins});
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_pc4 = 32'd20;
        in_ins = 32'h1004;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignores_push: count=%0d want 4", count); end
        checks++; if (out_pc4 !== 32'd4) begin errors++; $display("FAIL head_stable: out_pc4=%h want 4", out_pc4); end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_pc4, out_ins} !== sb[0]) begin
                errors++; $display("FAIL fill_pop_order: got v=%b %h want v=1 %h", out_valid, {out_pc4, out_ins}, sb[0]);
            end
            void'(sb.pop_front());
            tick();
        end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_drain_timeout: %0d left want 0", sb.size()); sb.delete(); end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_ins !== NOP) begin
            errors++; $display("FAIL drained_empty: count=%0d v=%b ins=%h want 0/0/%h", count, out_valid, out_ins, NOP);
        end
    endtask

    task automatic test_full_pop_push();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_pc4   = 32'h200 + 32'(4 * i);
            in_ins   = 32'h2000 + 32'(i);
            sb.push_back({in_pc4, in_ins});
            tick();
        end
        in_pc4    = 32'h300;
        in_ins    = 32'h3000;
        out_ready = 1'b1;
        checks++; if ({out_pc4, out_ins} !== sb[0]) begin errors++; $display("FAIL full_pop_head: got %h want %h", {out_pc4, out_ins}, sb[0]); end
        void'(sb.pop_front());
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_only: count=%0d want 3", count); end
        in_pc4 = 32'h304;
        in_ins = 32'h3004;
        checks++; if ({out_pc4, out_ins} !== sb[0]) begin errors++; $display("FAIL pushpop_head: got %h want %h", {out_pc4, out_ins}, sb[0]); end
        void'(sb.pop_front());
        sb.push_back({in_pc4, in_ins});
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pushpop_count: count=%0d want 3", count); end
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_pc4, out_ins} !== sb[0]) begin
                errors++; $display("FAIL pushpop_drain: got v=%b %h want v=1 %h", out_valid, {out_pc4, out_ins}, sb[0]);
            end
            void'(sb.pop_front());
            tick();
        end
        out_ready = 1'b0;
        checks++; if (sb.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL pushpop_end: left=%0d count=%0d want 0/0", sb.size(), count); sb.delete(); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int received = 0;
        bit do_push;
        bit do_pop;
        idle_inputs();
        for (int cyc = 0; cyc < 100 && received < 10; cyc++) begin
            out_ready = cyc[0];
            in_valid  = (sent < 10);
            in_pc4    = 32'h400 + 32'(4 * sent);
            in_ins    = 32'h20080000 + 32'(sent);
            do_pop  = (sb.size() != 0) && out_ready;
            do_push = in_valid && (sb.size() != DEPTH);
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                errors++; $display("FAIL wrap_valid: got %b want %b", out_valid, sb.size() != 0);
            end else if (sb.size() != 0 && {out_pc4, out_ins} !== sb[0]) begin
                errors++; $display("FAIL wrap_order: got %h want %h", {out_pc4, out_ins}, sb[0]);
            end
            if (do_pop) begin
                void'(sb.pop_front());
                received++;
            end
            if (do_push) begin
                sb.push_back({in_pc4, in_ins});
                sent++;
            end
            tick();
            checks++; if (count !== 3'(sb.size())) begin errors++; $display("FAIL wrap_count: got %0d want %0d", count, sb.size()); end
        end
        idle_inputs();
        checks++; if (received != 10) begin errors++; $display("FAIL wrap_timeout: received %0d want 10", received); sb.delete(); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc4   = 32'h500 + 32'(4 * i);
            in_ins   = 32'h5000 + 32'(i);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_prefill: count=%0d want 3", count); end
        flush     = 1'b1;
        in_pc4    = 32'h999;
        in_ins    = 32'h9999;
        out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: count=%0d v=%b want 0/0", count, out_valid); end
        checks++; if (out_ins !== NOP || out_pc4 !== 32'h0) begin errors++; $display("FAIL flush_nop: ins=%h pc4=%h want %h/0", out_ins, out_pc4, NOP); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_not_stored: count=%0d want 0", count); end
        in_valid = 1'b1;
        in_pc4   = 32'h540;
        in_ins   = 32'h5400;
        tick();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_pc4 !== 32'h540 || out_ins !== 32'h5400) begin
            errors++; $display("FAIL flush_next_entry: v=%b %h/%h want 1 540/5400", out_valid, out_pc4, out_ins);
        end
        out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_drain: count=%0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc4   = 32'h600 + 32'(4 * i);
            in_ins   = 32'h6000 + 32'(i);
            tick();
        end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_prefill: count=%0d want 2", count); end
        reset     = 1'b1;
        in_pc4    = 32'h6F0;
        in_ins    = 32'h6F00;
        out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_clear: count=%0d v=%b want 0/0", count, out_valid); end
        in_valid = 1'b1;
        in_pc4   = 32'h700;
        in_ins   = 32'hAC010000;
        sb.push_back({in_pc4, in_ins});
        tick();
        idle_inputs();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmid_count: count=%0d want 1", count); end
        checks++; if (out_valid !== 1'b1 || {out_pc4, out_ins} !== sb[0]) begin
            errors++; $display("FAIL rmid_first: v=%b %h want v=1 %h", out_valid, {out_pc4, out_ins}, sb[0]);
        end
        void'(sb.pop_front());
        out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain: count=%0d v=%b want 0/0", count, out_valid); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_fill_full();
        test_full_pop_push();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
